// File: rtl/seg_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_if
//  Brief    : Load/display bundle between upstream key/mode logic and the
//             6-digit segment scan controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface seg_scan_if;
    logic [23:0] data_in;
    logic [5:0]  dp_in;
    logic [5:0]  blink_in;
    logic        blank_lz;
    logic        load;
    logic        load_ack;
    logic        frame_start;
    logic [7:0]  dig;
    logic [5:0]  sel;

    modport master (
        output data_in, dp_in, blink_in, blank_lz, load,
        input  load_ack, frame_start, dig, sel
    );

    modport slave (
        input  data_in, dp_in, blink_in, blank_lz, load,
        output load_ack, frame_start, dig, sel
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Brief    : 6-digit common-anode scan scheduler with guard blanking,
//             leading-zero suppression, dp/blink and tear-free double buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int TIME_SCAN  = 50_000,
    parameter int TIME_GUARD = 16,
    parameter int TIME_500MS = 25_000_000
) (
    input wire        clk,
    input wire        rst_n,
    seg_scan_if.slave bus
);

    localparam int c_cnt_w = (TIME_SCAN  > 1) ? $clog2(TIME_SCAN)  : 1;
    localparam int c_blk_w = (TIME_500MS > 1) ? $clog2(TIME_500MS) : 1;

    localparam logic [c_cnt_w-1:0] c_scan_last = c_cnt_w'(TIME_SCAN - 1);
    localparam logic [c_cnt_w-1:0] c_guard     = c_cnt_w'(TIME_GUARD);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_blk_w-1:0] c_blk_last  = c_blk_w'(TIME_500MS - 1);
    localparam logic [c_blk_w-1:0] c_blk_one   = c_blk_w'(1);
    localparam logic [2:0]         c_idx_last  = 3'd5;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2:0]           r_idx;
    logic [c_blk_w-1:0]   r_blk_cnt;
    logic                 r_phase;
    logic                 r_pend;
    logic [23:0]          r_pend_data;
    logic [5:0]           r_pend_dp;
    logic [5:0]           r_pend_blink;
    logic [23:0]          r_sh_data;
    logic [5:0]           r_sh_dp;
    logic [5:0]           r_sh_blink;
    logic [5:0]           r_sel;
    logic [7:0]           r_dig;
    logic                 r_ack;
    logic                 r_fs;

    state_t               w_next_state;
    logic                 w_slot_end;
    logic                 w_frame_end;
    logic [3:0]           w_nib;
    logic [7:0]           w_seg;
    logic [5:0]           w_lz;
    logic                 w_lead;
    logic                 w_suppress;
    logic [7:0]           w_dig_drive;

    // Active-low segment pattern with the dp bit (7) left dark.
    function automatic logic [7:0] f_decode(input logic [3:0] nib);
        case (nib)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            4'hF: return 8'h8E;
        endcase
    endfunction

    assign w_slot_end  = (r_cnt == c_scan_last);
    assign w_frame_end = w_slot_end && (r_idx == c_idx_last);

    // Leading-zero run from digit 5 down; digit 0 always stays visible.
    always_comb begin
        w_lz   = 6'b0;
        w_lead = 1'b1;
        for (int i = 5; i >= 1; i--) begin
            w_lead  = w_lead && (r_sh_data[i*4 +: 4] == 4'h0);
            w_lz[i] = w_lead;
        end
    end

    always_comb begin
        w_nib        = r_sh_data[{r_idx, 2'b00} +: 4];
        w_seg        = f_decode(w_nib);
        w_suppress   = (bus.blank_lz && w_lz[r_idx]) ||
                       (r_phase && r_sh_blink[r_idx]);
        w_dig_drive  = w_suppress ? 8'hFF : {~r_sh_dp[r_idx], w_seg[6:0]};
        w_next_state = (r_cnt < c_guard) ? ST_BLANK : ST_DRIVE;
    end

    // Slot counter and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == c_idx_last) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    // Free-running blink phase; deliberately unaffected by loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk_cnt <= '0;
            r_phase   <= 1'b0;
        end else if (r_blk_cnt == c_blk_last) begin
            r_blk_cnt <= '0;
            r_phase   <= ~r_phase;
        end else begin
            r_blk_cnt <= r_blk_cnt + c_blk_one;
        end
    end

    // Double buffer: a load on the boundary cycle commits the old pending
    // value and parks the new one for the following frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend       <= 1'b0;
            r_pend_data  <= 24'h0;
            r_pend_dp    <= 6'h0;
            r_pend_blink <= 6'h0;
            r_sh_data    <= 24'h0;
            r_sh_dp      <= 6'h0;
            r_sh_blink   <= 6'h0;
            r_ack        <= 1'b0;
        end else begin
            if (w_frame_end && r_pend) begin
                r_sh_data  <= r_pend_data;
                r_sh_dp    <= r_pend_dp;
                r_sh_blink <= r_pend_blink;
            end
            if (bus.load) begin
                r_pend_data  <= bus.data_in;
                r_pend_dp    <= bus.dp_in;
                r_pend_blink <= bus.blink_in;
                r_pend       <= 1'b1;
            end else if (w_frame_end) begin
                r_pend       <= 1'b0;
            end
            r_ack <= w_frame_end && r_pend;
        end
    end

    // Scan FSM; outputs lag the cnt/idx state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BLANK;
            r_sel   <= 6'h3F;
            r_dig   <= 8'hFF;
            r_fs    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_fs    <= w_frame_end;
            case (w_next_state)
                ST_BLANK: begin
                    r_sel <= 6'h3F;
                    r_dig <= 8'hFF;
                end
                ST_DRIVE: begin
                    r_sel <= ~(6'b000001 << r_idx);
                    r_dig <= w_dig_drive;
                end
                default: begin
                    r_sel <= 6'h3F;
                    r_dig <= 8'hFF;
                end
            endcase
        end
    end

    assign bus.sel         = r_sel;
    assign bus.dig         = r_dig;
    assign bus.load_ack    = r_ack;
    assign bus.frame_start = r_fs;

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Scan scheduler for the 6-digit common-anode segment display. It time-multiplexes one shared 8-bit segment bus across six digit selects, with a blanking guard between digits, leading-zero suppression, per-digit decimal point and per-digit 500 ms blink. New display data is double-buffered and committed only at frame boundaries, so a frame never tears. Upstream key/mode logic drives it through a load/ack handshake.

Parameters:
TIME_SCAN, 50_000, cycles per digit slot (1 ms at 50 MHz); must be > TIME_GUARD.
TIME_GUARD, 16, cycles at the start of each slot with all digits deselected (anti-ghosting); must be ≥ 1.
TIME_500MS, 25_000_000, cycles per blink half-period.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
data_in  input  24  six hex nibbles; [3:0] = digit 0 (rightmost), [23:20] = digit 5
dp_in  input  6  decimal point enable per digit, 1 = lit
blink_in  input  6  blink enable per digit
blank_lz  input  1  level; 1 = suppress leading zeros
load  input  1  1-cycle request to capture data_in/dp_in/blink_in
load_ack  output  1  1-cycle pulse when captured data becomes displayed
frame_start  output  1  1-cycle pulse at start of slot 0
dig  output  8  active-low segments, bit7 = dp, bits6:0 = g..a
sel  output  6  active-low digit select, sel[i] = digit i

Behaviour:
- Clock: one clock domain. Reset: asynchronous, active-low, on rst_n. Reset values: sel=6'h3F, dig=8'hFF, load_ack=0, frame_start=0. Internally: slot counter=0, digit index=0, state=BLANK, blink phase=0 (visible), pending flag=0, shadow and pending registers all 0. Reset mid-frame takes effect immediately.
- Slot counter: cnt runs 0..TIME_SCAN-1. At the terminal count, cnt wraps to 0 and idx advances 0→1→…→5→0.
- Frame: one frame is 6*TIME_SCAN cycles.
- FSM, 2 states:
  - BLANK when cnt < TIME_GUARD: sel=6'h3F, dig=8'hFF.
  - DRIVE otherwise: sel = ~(1<<idx); dig = decode of the shadow nibble for idx.
- Output timing: outputs are registered, with 1-cycle latency from the cnt/idx state.
- Decode, active-low with bit7=1 before dp:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E.
  - dig[7] is forced to 0 when shadow dp[idx]=1.
- Leading-zero blank: with blank_lz=1, digits from 5 downward whose nibble is 0 are blanked (dig=8'hFF, dp included) up to the first nonzero nibble. Digit 0 is never blanked. blank_lz is sampled live.
- Blink: a free-running counter toggles the blink phase every TIME_500MS cycles. While phase=1, digits with shadow blink[idx]=1 output dig=8'hFF; sel still drives. Blink does not reset on load.
- Load handshake:
  - load=1 captures data_in/dp_in/blink_in into the pending registers and sets pending=1. Back-to-back loads overwrite pending; last wins.
  - Frame boundary = the cycle where idx wraps 5→0.
  - At a frame boundary with pending=1: shadow←pending, pending←0, and load_ack pulses in the following cycle, aligned with frame_start.
  - load on the boundary cycle: the old pending is committed and the new value is captured into pending for the next frame. If pending was 0, the new value waits one full frame.
- frame_start pulses every frame, independent of load.
- Arithmetic: counter widths are sized with $clog2 of each parameter; no overflow is permitted.

Test Plan:
Bench parameters for all scenarios: TIME_SCAN=10, TIME_GUARD=2, TIME_500MS=100.
1. Reset, then no load → sel cycles 3E,3D,3B,37,2F,1F, each slot having 2 cycles of 3F followed by 8 cycles driven; dig=C0 in every driven cycle; frame_start every 60 cycles.
2. load with data_in=24'h012345, dp_in=6'b000100, blank_lz=0, mid-frame → display unchanged until the next boundary; then load_ack=1 coincident with frame_start; digit2 dig=0x30 (3 with dp), digit0=92, digit5=C0.
3. blank_lz=1 with data 24'h000A05 → digits 5,4,3 dig=FF; digit2=88, digit1=C0, digit0=92. Data 24'h000000 → only digit0 shows C0.
4. blink_in=6'b000001, data 24'h000007 → digit0 shows F8 for 100 cycles, then FF for 100 cycles, repeating; other digits unaffected.
5. Two loads (24'h111111, then 24'h222222) within one frame, followed by a load exactly on the boundary cycle → 22 digits (A4) appear in the next frame; the boundary-cycle data appears one frame later; exactly 2 load_ack pulses.
6. rst_n low for 1 cycle during DRIVE of digit 3 with pending=1 → sel=3F and dig=FF asynchronously; pending is discarded; after release, the display restarts at digit 0 showing C0.
